// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents:
//   DW_DEFAULT  default divisor/quotient/remainder width
//   ITER        quotient bits produced per divide (one per clock) at the default width
//   Q_MAX/Q_MIN saturation values at the default width
//   state_e     controller state encoding
package div_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned ITER       = 2 * DW_DEFAULT;

  localparam logic [DW_DEFAULT-1:0] Q_MAX = 8'h7F;
  localparam logic [DW_DEFAULT-1:0] Q_MIN = 8'h80;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish,
    StDone
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem       in  DW  current partial remainder (always < dvs)
//   bit_in    in  1   next dividend bit shifted into the remainder
//   dvs       in  DW  divisor magnitude (unsigned, non-zero)
//   rem_next  out DW  partial remainder after the trial subtraction
//   q_bit     out 1   quotient bit produced by this step
module div_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] rem,
  input  logic          bit_in,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] rem_next,
  output logic          q_bit
);

  logic [DW:0] trial;

  always_comb begin
    trial = {rem, bit_in};
    q_bit = (trial >= {1'b0, dvs});
    // The restored result is below dvs, so the low DW bits of the modular
    // difference are exact.
    rem_next = q_bit ? (trial[DW-1:0] - dvs) : trial[DW-1:0];
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient and
// remainder, truncating toward zero, one quotient bit per clock (restoring algorithm).
// Ports:
//   clk          in   1     clock
//   rst_n        in   1     asynchronous active-low reset
//   en           in   1     level request; high = divide, low = abort / return to idle
//   dividend     in   2*DW  signed dividend, held stable while en=1
//   divisor      in   DW    signed divisor, held stable while en=1
//   quotient     out  DW    signed quotient, saturated on overflow
//   remainder    out  DW    signed remainder, takes the sign of the dividend
//   ready        out  1     result valid
//   div_by_zero  out  1     divisor was zero (valid with ready)
//   overflow     out  1     quotient did not fit and was saturated (valid with ready)
module booth_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            ready,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int unsigned Iter = 2 * DW;
  localparam int unsigned CntW = $clog2(Iter);
  localparam logic [CntW-1:0] CntLast = CntW'(Iter - 1);

  // Largest magnitudes representable for a positive / negative quotient.
  localparam logic [2*DW-1:0] PosLim = (2*DW)'((2 ** (DW - 1)) - 1);
  localparam logic [2*DW-1:0] NegLim = (2*DW)'(2 ** (DW - 1));
  localparam logic [DW-1:0]   QMax   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   QMin   = {1'b1, {(DW-1){1'b0}}};

  state_e          state_q;
  logic [2*DW-1:0] dvd_q;     // dividend magnitude, shifted out MSB first
  logic [2*DW-1:0] quo_q;     // quotient magnitude, shifted in LSB first
  logic [DW-1:0]   dvs_q;     // divisor magnitude
  logic [DW-1:0]   rem_q;     // partial remainder magnitude
  logic [CntW-1:0] cnt_q;
  logic            q_sign_q;
  logic            r_sign_q;
  logic            dbz_q;

  logic [2*DW-1:0] dvd_abs;
  logic [DW-1:0]   dvs_abs;
  logic [DW-1:0]   step_rem;
  logic            step_q;
  logic            q_ovf;
  logic [DW-1:0]   q_signed;
  logic [DW-1:0]   r_signed;

  // Magnitudes as unsigned: the most negative value maps to 2**(width-1).
  always_comb begin
    dvd_abs = dividend[2*DW-1] ? (~dividend + 1'b1) : dividend;
    dvs_abs = divisor[DW-1] ? (~divisor + 1'b1) : divisor;
  end

  div_step #(
    .DW(DW)
  ) u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[2*DW-1]),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Result formatting; a negative quotient may reach one step further than a positive one.
  always_comb begin
    q_ovf    = q_sign_q ? (quo_q > NegLim) : (quo_q > PosLim);
    q_signed = q_sign_q ? (~quo_q[DW-1:0] + 1'b1) : quo_q[DW-1:0];
    r_signed = r_sign_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_sign_q    <= 1'b0;
      r_sign_q    <= 1'b0;
      dbz_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            dvd_q    <= dvd_abs;
            dvs_q    <= dvs_abs;
            q_sign_q <= dividend[2*DW-1] ^ divisor[DW-1];
            r_sign_q <= dividend[2*DW-1];
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            dbz_q    <= (divisor == '0);
            state_q  <= (divisor == '0) ? StFinish : StRun;
          end
        end
        StRun: begin
          if (!en) begin
            state_q <= StIdle;
          end else begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[2*DW-2:0], 1'b0};
            quo_q <= {quo_q[2*DW-2:0], step_q};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StFinish;
            end
          end
        end
        StFinish: begin
          if (!en) begin
            state_q <= StIdle;
          end else begin
            ready <= 1'b1;
            state_q <= StDone;
            if (dbz_q) begin
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else begin
              quotient    <= q_ovf ? (q_sign_q ? QMin : QMax) : q_signed;
              remainder   <= r_signed;
              div_by_zero <= 1'b0;
              overflow    <= q_ovf;
            end
          end
        end
        StDone: begin
          if (!en) begin
            ready   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed corner cases, abort, async reset mid-run,
// and randomized operands against a plain-arithmetic reference model.
module tb_booth_divider;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ready;
  logic        div_by_zero;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  booth_divider #(
    .DW(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // C-style truncating division on plain integers, then saturation to signed 8 bits.
  function automatic void model(input int a, input int b, output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int qi;
    int ri;
    if (b == 0) begin
      q = 8'h00; r = 8'h00; dz = 1'b1; ov = 1'b0;
    end else begin
      qi = a / b;
      ri = a % b;
      dz = 1'b0;
      ov = (qi > 127) || (qi < -128);
      q  = (qi > 127) ? 8'h7F : (qi < -128) ? 8'h80 : 8'(qi);
      r  = 8'(ri);
    end
  endfunction

  task automatic run_op(input int a, input int b, input string tag);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ed;
    logic       eo;
    int         cycles;
    int         lat;
    model(a, b, eq, er, ed, eo);
    lat = (b == 0) ? 1 : 17;
    @(negedge clk);
    dividend = 16'(a);
    divisor  = 8'(b);
    en       = 1'b1;
    @(negedge clk);  // load edge E0 has passed
    check({tag, "/busy"}, 32'(ready), 32'd0);
    cycles = 0;
    while (!ready && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "/latency"}, 32'(cycles), 32'(lat));
    check({tag, "/quotient"}, 32'(quotient), 32'(eq));
    check({tag, "/remainder"}, 32'(remainder), 32'(er));
    check({tag, "/dbz"}, 32'(div_by_zero), 32'(ed));
    check({tag, "/ovf"}, 32'(overflow), 32'(eo));
    // Result must hold while en stays high, whatever the operands do.
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    repeat (3) @(negedge clk);
    check({tag, "/hold_ready"}, 32'(ready), 32'd1);
    check({tag, "/hold_q"}, 32'(quotient), 32'(eq));
    en = 1'b0;
    @(negedge clk);
    check({tag, "/drop_ready"}, 32'(ready), 32'd0);
    check({tag, "/keep_r"}, 32'(remainder), 32'(er));
  endtask

  initial begin
    logic [7:0] pq;
    logic [7:0] pr;
    logic       pd;
    logic       po;
    int         a;
    int         b;

    rst_n    = 1'b0;
    en       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst/quotient", 32'(quotient), 32'd0);
    check("rst/remainder", 32'(remainder), 32'd0);
    check("rst/ready", 32'(ready), 32'd0);
    check("rst/dbz", 32'(div_by_zero), 32'd0);
    check("rst/ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    run_op(100, 7, "p100_p7");
    run_op(-100, 7, "n100_p7");
    run_op(100, -7, "p100_n7");
    run_op(1234, 0, "div0");
    run_op(16384, -128, "qmin");
    run_op(-32768, -128, "ovf_neg");
    run_op(-1, 5, "small_neg");
    run_op(1000, 3, "ovf_pos");

    // Abort at E5: no result, outputs keep the previous (overflow) result.
    pq = quotient; pr = remainder; pd = div_by_zero; po = overflow;
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 8'd5;
    en       = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("abort/ready", 32'(ready), 32'd0);
    check("abort/quotient", 32'(quotient), 32'(pq));
    check("abort/remainder", 32'(remainder), 32'(pr));
    check("abort/flags", 32'({div_by_zero, overflow}), 32'({pd, po}));
    run_op(50, 5, "after_abort");

    // Asynchronous reset in the middle of a run (between E7 and E8).
    @(negedge clk);
    dividend = 16'd77;
    divisor  = 8'd3;
    en       = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/quotient", 32'(quotient), 32'd0);
    check("midrst/ready", 32'(ready), 32'd0);
    en = 1'b0;
    #1 rst_n = 1'b1;
    run_op(77, 3, "after_rst");

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      if (i % 3 != 0) a = a / (1 << $urandom_range(0, 8));
      b = int'($urandom_range(0, 255)) - 128;
      if (i % 10 == 0) b = 0;
      run_op(a, b, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
